// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default baud divider and frame format.
// Kept separate so the future receiver can reuse the same constants.
package uart_pkg;

  localparam int unsigned UART_CLK_DIV_DEFAULT = 434;

  localparam int unsigned UART_START_BITS = 1;
  localparam int unsigned UART_STOP_BITS  = 1;

  localparam logic [1:0] UART_ST_IDLE  = 2'd0;
  localparam logic [1:0] UART_ST_START = 2'd1;
  localparam logic [1:0] UART_ST_DATA  = 2'd2;
  localparam logic [1:0] UART_ST_STOP  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = UART_ST_IDLE,
    ST_START = UART_ST_START,
    ST_DATA  = UART_ST_DATA,
    ST_STOP  = UART_ST_STOP
  } uart_state_e;

  // Clock cycles from the start-bit edge to the end of the stop bit.
  function automatic int unsigned uart_frame_cycles(input int unsigned clk_div,
                                                    input int unsigned dat_width);
    return clk_div * (dat_width + UART_START_BITS + UART_STOP_BITS);
  endfunction

endpackage

// File: rtl/fifo_uart_tx_if.sv
// FIFO read port plus serial-side status, as seen by the UART transmitter.
// master = transmitter side, slave = FIFO/board side.
interface fifo_uart_tx_if #(
  parameter int unsigned dat_width = 8
);

  logic                 tx_en;
  logic                 fifo_empty;
  logic [dat_width-1:0] fifo_data;
  logic                 fifo_rd;
  logic                 tx;
  logic                 busy;

  modport master (
    input  tx_en,
    input  fifo_empty,
    input  fifo_data,
    output fifo_rd,
    output tx,
    output busy
  );

  modport slave (
    output tx_en,
    output fifo_empty,
    output fifo_data,
    input  fifo_rd,
    input  tx,
    input  busy
  );

endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..clk_div-1 and flags the last cycle of each bit.
// bit_tick_o is registered and is high exactly while the count sits at its terminal value.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int unsigned clk_div = UART_CLK_DIV_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  output logic bit_tick_o
);

  localparam int unsigned    CNT_W   = (clk_div > 1) ? $clog2(clk_div) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(clk_div - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  // Next count wraps at the terminal value; the tick is precomputed so it stays registered.
  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (clear_i || (cnt_q == CNT_MAX)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    tick_d = !clear_i && (cnt_d == CNT_MAX);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign bit_tick_o = tick_q;

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops bytes from a show-ahead FIFO and sends each as an 8N1-style frame, LSB first.
// One IDLE cycle separates back-to-back frames.
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned dat_width = 8,
  parameter int unsigned clk_div   = UART_CLK_DIV_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  fifo_uart_tx_if.master bus
);

  localparam int unsigned      IDX_W    = (dat_width > 1) ? $clog2(dat_width) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(dat_width - 1);

  uart_state_e          state_q, state_d;
  logic [dat_width-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 tx_q, tx_d;
  logic                 rd_q, rd_d;
  logic                 busy_q, busy_d;
  logic                 baud_clr_c;
  logic                 bit_tick;

  // Held in clear while idle so every frame starts on a fresh bit period.
  uart_baud_gen #(
    .clk_div (clk_div)
  ) u_baud (
    .clk        (clk),
    .reset      (reset),
    .clear_i    (baud_clr_c),
    .bit_tick_o (bit_tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      tx_q    <= 1'b1;
      rd_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
      rd_q    <= rd_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    idx_d      = idx_q;
    tx_d       = tx_q;
    rd_d       = 1'b0;
    busy_d     = busy_q;
    baud_clr_c = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        baud_clr_c = 1'b1;
        tx_d       = 1'b1;
        busy_d     = 1'b0;
        if (bus.tx_en && !bus.fifo_empty) begin
          shift_d = bus.fifo_data;
          rd_d    = 1'b1;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
          state_d = ST_START;
        end
      end

      ST_START: begin
        if (bit_tick) begin
          idx_d   = '0;
          tx_d    = shift_q[0];
          state_d = ST_DATA;
        end
      end

      ST_DATA: begin
        if (bit_tick) begin
          if (idx_q == IDX_LAST) begin
            tx_d    = 1'b1;
            state_d = ST_STOP;
          end else begin
            shift_d = shift_q >> 1;
            idx_d   = idx_q + IDX_W'(1);
            tx_d    = shift_d[0];
          end
        end
      end

      ST_STOP: begin
        if (bit_tick) begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.fifo_rd = rd_q;
  assign bus.tx      = tx_q;
  assign bus.busy    = busy_q;

endmodule
